// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR word-stream checker: FSM encoding and the
// default feedback polynomial used by both generator and checker.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [15:0] DEFAULT_POLY = 16'hD008;

endpackage : lfsr_pkg

// File: rtl/lfsr_next.sv
// Single-step Fibonacci LFSR update: shift left, feed back the parity of the
// tapped bits into bit 0. Shared with the generator so both ends agree.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY)
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o
);

  // Next LFSR state from the current one
  always_comb begin
    y_o = {x_i[WIDTH-2:0], ^(x_i & POLY)};
  end

endmodule : lfsr_next

// File: rtl/lfsr_checker.sv
// Self-synchronizing checker for the LFSR word stream. Seeds from a nonzero
// word, verifies LOCK_CNT consecutive predictions, then free-runs its own
// prediction while LOCKED so a single corrupted word costs one mismatch.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(DEFAULT_POLY),
  parameter int               LOCK_CNT   = 8,
  parameter int               UNLOCK_CNT = 4,
  parameter int               CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             i_stb,
  input  logic [WIDTH-1:0] i_data,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN   = RUN_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0] UNLOCK_RUN = RUN_W'(UNLOCK_CNT);

  state_e           state_q;
  logic [WIDTH-1:0] ref_q;
  logic [RUN_W-1:0] run_q;
  logic             locked_q;
  logic             err_q;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] nxt_data_s;
  logic [WIDTH-1:0] nxt_ref_s;
  logic             match_s;
  logic [RUN_W-1:0] run_inc_s;
  logic             count_word_s;
  logic             count_err_s;

  // Prediction from the received word (self-sync) and from ref (free-run)
  lfsr_next #(.WIDTH(WIDTH), .POLY(POLY)) u_nxt_data (.x_i(i_data), .y_o(nxt_data_s));
  lfsr_next #(.WIDTH(WIDTH), .POLY(POLY)) u_nxt_ref  (.x_i(ref_q),  .y_o(nxt_ref_s));

  assign match_s      = (i_data == ref_q);
  assign run_inc_s    = run_q + RUN_W'(1);
  assign count_word_s = i_stb && (state_q == ST_LOCKED);
  assign count_err_s  = count_word_s && !match_s;

  // Saturating statistics counters; clr wins over a same-cycle count
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (clr) begin
      word_cnt_d = '0;
      err_cnt_d  = '0;
    end else begin
      if (count_word_s && (word_cnt_q != {CNT_W{1'b1}})) begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end else begin
        word_cnt_d = word_cnt_q;
      end
      if (count_err_s && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end
  end

  // Register the statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Acquisition / tracking FSM with registered locked and err outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SEARCH;
      ref_q    <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (i_stb) begin
        case (state_q)
          ST_SEARCH: begin
            // all-zero is the LFSR lock-up word and can never seed
            if (i_data != '0) begin
              ref_q   <= nxt_data_s;
              run_q   <= '0;
              state_q <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            ref_q <= nxt_data_s;
            if (match_s) begin
              if (run_inc_s == LOCK_RUN) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
                run_q    <= '0;
              end else begin
                run_q <= run_inc_s;
              end
            end else begin
              run_q <= '0;
              if (i_data == '0) begin
                state_q <= ST_SEARCH;
              end
            end
          end
          ST_LOCKED: begin
            ref_q <= nxt_ref_s;
            if (!match_s) begin
              err_q <= 1'b1;
              if (run_inc_s == UNLOCK_RUN) begin
                state_q  <= ST_SEARCH;
                locked_q <= 1'b0;
                run_q    <= '0;
              end else begin
                run_q <= run_inc_s;
              end
            end else begin
              run_q <= '0;
            end
          end
          default: begin
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
            run_q    <= '0;
          end
        endcase
      end
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign word_cnt = word_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule : lfsr_checker

// File: doc/lfsr_checker.md
# lfsr_checker

Self-synchronizing checker for the word stream produced by the team's Fibonacci LFSR generator, whose state is the transmitted word. It sits on the receive side of the IDELAY minitest data path, after the deserializer. It locks onto the incoming sequence, predicts each next word, and reports lock status, per-word error pulses and saturating word/error counts. The host uses these to sweep delay taps.

## Interface
- WIDTH, 16, word and LFSR width; minimum 2.
- POLY, 16'hD008, feedback tap mask; must match the generator.
- LOCK_CNT, 8, consecutive matching words required to declare lock; minimum 1.
- UNLOCK_CNT, 4, consecutive mismatches in LOCKED that drop lock; minimum 1.
- CNT_W, 32, width of the statistics counters.
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of word_cnt and err_cnt; lock state is kept.
- i_stb  in  1  i_data is valid this cycle.
- i_data  in  WIDTH  received word.
- locked  out  1  checker is in LOCKED.
- err  out  1  one-cycle pulse: a word received in LOCKED mismatched.
- word_cnt  out  CNT_W  words checked while LOCKED; saturates at all-ones.
- err_cnt  out  CNT_W  mismatched words while LOCKED; saturates at all-ones.

## Operation
- nxt(x) = {x[WIDTH-2:0], ^(x & POLY)}. This is the generator's single-step update.
- ref is a WIDTH-bit register holding the expected next word. match = (i_data == ref).
- States: SEARCH, VERIFY, LOCKED. The run counter has ceil(log2(max(LOCK_CNT,UNLOCK_CNT)+1)) bits.
- SEARCH:
  - On i_stb with i_data != 0: ref <= nxt(i_data), run <= 0, go to VERIFY.
  - All-zero words are the LFSR lock-up state. They are ignored and the block stays in SEARCH.
- VERIFY, on i_stb:
  - Always ref <= nxt(i_data). This is the self-sync step.
  - On match: run++. When run reaches LOCK_CNT, go to LOCKED and set run <= 0.
  - On mismatch: run <= 0 and stay in VERIFY. If i_data == 0, go to SEARCH instead.
- LOCKED, on i_stb:
  - ref <= nxt(ref). The LOCKED state free-runs, so a single-bit error costs exactly one mismatch.
  - word_cnt++.
  - On mismatch: err pulse, err_cnt++, run++. When run reaches UNLOCK_CNT, go to SEARCH; locked drops.
  - On match: run <= 0.
- No i_stb: nothing changes, and err is 0 that cycle.
- Counters saturate and never wrap.
- clr has priority over counting. A word accepted in the same cycle as clr is not counted, and both counters read 0 the next cycle. err, locked and the FSM still act on that word normally.
- Reset: state = SEARCH, ref = 0, run = 0, locked = 0, err = 0, word_cnt = 0, err_cnt = 0.
- Reset asserted mid-stream returns all of the above immediately. After release, re-acquisition starts from the next valid nonzero word.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- err asserts in the cycle after the i_stb cycle of the offending word.
- word_cnt and err_cnt update in the cycle after the i_stb cycle of the counted word.
- Acquisition takes LOCK_CNT+1 valid words: one seed plus LOCK_CNT matches.
- locked rises in the cycle after the i_stb of the last of those words.
- locked falls in the cycle after the i_stb of the UNLOCK_CNT-th consecutive mismatch. err is also high in that same cycle.
- i_stb may be asserted every cycle. Gaps in i_stb are allowed and do not advance ref.

## Structure
- Package lfsr_pkg holds:
  - the state encoding constants ST_SEARCH = 0, ST_VERIFY = 1, ST_LOCKED = 2, in a 2-bit state register;
  - the default POLY value.
- Sub-module lfsr_next (parameters WIDTH and POLY) is the combinational nxt().
  - It is instantiated twice: once on i_data and once on ref.
  - It is shared with the generator so both sides use the same polynomial.
- The FSM, run counter and statistics counters live in lfsr_checker.

## Test plan
- Clean lock:
  - Stimulus: after reset, i_stb every cycle with seed 0x0001 generator words 0x0001, 0x0002, 0x0004, 0x0008, 0x0011, ....
  - Response: locked rises in the cycle after the 9th word's i_stb; err stays 0; word_cnt counts LOCKED words exactly.
- Single-bit error in LOCKED:
  - Stimulus: flip bit 3 of one word.
  - Response: exactly one err pulse; err_cnt = 1; locked stays 1; the following words match.
- Loss of lock:
  - Stimulus: 4 consecutive corrupted words.
  - Response: 4 err pulses; locked falls with the 4th pulse.
  - Follow-up: clean words resume; locked returns after 9 valid words.
- Zero and gaps:
  - Stimulus: 0x0000 words in SEARCH are ignored.
  - Stimulus: i_stb toggling 1-0-1 during VERIFY.
  - Response: lock timing is identical to the gap-free case when counted in valid words.
- Clear and saturation:
  - Stimulus: clr together with an erroneous i_stb.
  - Response: err pulses and both counters read 0 the next cycle.
  - Stimulus: with CNT_W = 4, drive 20 locked words.
  - Response: word_cnt holds at 15.
- Reset mid-lock:
  - Stimulus: assert rst_n low asynchronously between clock edges while locked.
  - Response: locked, err and both counters go to 0 immediately; clean re-acquisition follows release.
